// File: rtl/rk4_pkg.sv
// rk4_pkg -- shared definitions for the RK4 slope sequencer.
//   N_DEF / FRAC_DEF : default word width and fractional bits (Q16.16)
//   ONE / HALF       : Q16.16 constants 1.0 and 0.5
//   rk4_state_e      : sequencer FSM states
package rk4_pkg;

  localparam int N_DEF    = 32;
  localparam int FRAC_DEF = 16;

  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] HALF = 32'h0000_8000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EVAL1 = 3'd1,
    EVAL2 = 3'd2,
    EVAL3 = 3'd3,
    EVAL4 = 3'd4,
    DONE  = 3'd5
  } rk4_state_e;

endpackage

// File: rtl/fx_mul_q16.sv
// fx_mul_q16 -- signed fixed-point multiply, combinational.
//   a, b : signed N-bit operands with FRAC fractional bits
//   p    : product bits [N+FRAC-1:FRAC] of the full 2N-bit signed product
//          (truncation toward negative infinity)
// Build option: define RK4_SAT_EN to clamp overflowing products to the most
// positive / most negative N-bit value; otherwise the kept bits simply wrap.
module fx_mul_q16 #(
  parameter int N    = 32,
  parameter int FRAC = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] p
);

  logic [2*N-1:0] a_ext_s;
  logic [2*N-1:0] b_ext_s;
  logic [2*N-1:0] prod_s;
  logic           unused_s;

  // Sign-extending both operands to 2N bits makes the low 2N bits of an
  // unsigned multiply equal to the exact signed product.
  assign a_ext_s = {{N{a[N-1]}}, a};
  assign b_ext_s = {{N{b[N-1]}}, b};
  assign prod_s  = a_ext_s * b_ext_s;

`ifdef RK4_SAT_EN
  logic [N-FRAC:0] top_s;
  logic            ovf_s;

  // The result fits only if every bit from the kept sign bit upward agrees.
  assign top_s = prod_s[2*N-1:N+FRAC-1];
  assign ovf_s = (top_s != {(N-FRAC+1){1'b0}}) && (top_s != {(N-FRAC+1){1'b1}});

  // Select the in-range slice or the clamp value matching the true sign.
  always_comb begin
    if (!ovf_s) begin
      p = prod_s[N+FRAC-1:FRAC];
    end else if (prod_s[2*N-1]) begin
      p = {1'b1, {(N-1){1'b0}}};
    end else begin
      p = {1'b0, {(N-1){1'b1}}};
    end
  end

  assign unused_s = ^prod_s[FRAC-1:0];
`else
  assign p        = prod_s[N+FRAC-1:FRAC];
  assign unused_s = ^{prod_s[2*N-1:N+FRAC], prod_s[FRAC-1:0]};
`endif

endmodule

// File: rtl/rk4_k_sequencer.sv
// rk4_k_sequencer -- sequences the four f() evaluations of one RK4 step and
// produces the slopes k1..k4 = h*f(...) for a downstream y update.
//   CLK, RST_N        : clock (rising edge), asynchronous active-low reset
//   START             : begin a step (honoured only while idle)
//   T_IN, Y_IN, H     : step operands, latched on START
//   BUSY              : high in every state except IDLE
//   F_REQ, F_T, F_Y   : request to evaluate f(F_T, F_Y); held until F_ACK
//   F_ACK, F_VAL      : evaluation result handshake
//   K_1..K_4, K_VALID : slopes, refreshed together with a one-cycle K_VALID
// Build option: RK4_SAT_EN selects saturating products in fx_mul_q16.
module rk4_k_sequencer
  import rk4_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic [N-1:0] T_IN,
  input  logic [N-1:0] Y_IN,
  input  logic [N-1:0] H,
  output logic         BUSY,
  output logic         F_REQ,
  output logic [N-1:0] F_T,
  output logic [N-1:0] F_Y,
  input  logic         F_ACK,
  input  logic [N-1:0] F_VAL,
  output logic [N-1:0] K_1,
  output logic [N-1:0] K_2,
  output logic [N-1:0] K_3,
  output logic [N-1:0] K_4,
  output logic         K_VALID
);

  rk4_state_e   state_r;
  logic [N-1:0] t_r, y_r, h_r;
  logic [N-1:0] k1_r, k2_r, k3_r, k4_r;
  logic [N-1:0] k_out1_r, k_out2_r, k_out3_r, k_out4_r;
  logic         busy_r, f_req_r, k_valid_r;
  logic [N-1:0] f_t_r, f_y_r;
  logic [N-1:0] prod_s;
  logic [N-1:0] nxt_t_s, nxt_y_s;
  logic         acc_s;

  // Arithmetic halving: shift right by one, replicating the sign bit.
  function automatic logic [N-1:0] half_of(input logic [N-1:0] v);
    half_of = {v[N-1], v[N-1:1]};
  endfunction

  fx_mul_q16 #(.N(N), .FRAC(FRAC)) u_mul (
    .a(h_r),
    .b(F_VAL),
    .p(prod_s)
  );

  // An acknowledge only counts while a request is actually outstanding.
  assign acc_s = f_req_r & F_ACK;

  // f arguments for the stage being set up (EVAL1 is loaded directly on START).
  always_comb begin
    nxt_t_s = t_r;
    nxt_y_s = y_r;
    case (state_r)
      EVAL2: begin
        nxt_t_s = t_r + half_of(h_r);
        nxt_y_s = y_r + half_of(k1_r);
      end
      EVAL3: begin
        nxt_t_s = t_r + half_of(h_r);
        nxt_y_s = y_r + half_of(k2_r);
      end
      EVAL4: begin
        nxt_t_s = t_r + h_r;
        nxt_y_s = y_r + k3_r;
      end
      default: begin
        nxt_t_s = t_r;
        nxt_y_s = y_r;
      end
    endcase
  end

  // Sequencer FSM. Within each EVAL state f_req_r doubles as the phase flag:
  // low = set up arguments (the one-cycle gap), high = wait for F_ACK.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r   <= IDLE;
      t_r       <= {N{1'b0}};
      y_r       <= {N{1'b0}};
      h_r       <= {N{1'b0}};
      k1_r      <= {N{1'b0}};
      k2_r      <= {N{1'b0}};
      k3_r      <= {N{1'b0}};
      k4_r      <= {N{1'b0}};
      k_out1_r  <= {N{1'b0}};
      k_out2_r  <= {N{1'b0}};
      k_out3_r  <= {N{1'b0}};
      k_out4_r  <= {N{1'b0}};
      busy_r    <= 1'b0;
      f_req_r   <= 1'b0;
      f_t_r     <= {N{1'b0}};
      f_y_r     <= {N{1'b0}};
      k_valid_r <= 1'b0;
    end else begin
      k_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (START) begin
            t_r     <= T_IN;
            y_r     <= Y_IN;
            h_r     <= H;
            f_t_r   <= T_IN;
            f_y_r   <= Y_IN;
            f_req_r <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= EVAL1;
          end else begin
            busy_r  <= 1'b0;
            f_req_r <= 1'b0;
          end
        end
        EVAL1, EVAL2, EVAL3, EVAL4: begin
          if (acc_s) begin
            f_req_r <= 1'b0;
            case (state_r)
              EVAL1: begin
                k1_r    <= prod_s;
                state_r <= EVAL2;
              end
              EVAL2: begin
                k2_r    <= prod_s;
                state_r <= EVAL3;
              end
              EVAL3: begin
                k3_r    <= prod_s;
                state_r <= EVAL4;
              end
              default: begin
                k4_r    <= prod_s;
                state_r <= DONE;
              end
            endcase
          end else if (!f_req_r) begin
            f_t_r   <= nxt_t_s;
            f_y_r   <= nxt_y_s;
            f_req_r <= 1'b1;
          end else begin
            f_req_r <= 1'b1;
          end
        end
        DONE: begin
          k_out1_r  <= k1_r;
          k_out2_r  <= k2_r;
          k_out3_r  <= k3_r;
          k_out4_r  <= k4_r;
          k_valid_r <= 1'b1;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          f_req_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign BUSY    = busy_r;
  assign F_REQ   = f_req_r;
  assign F_T     = f_t_r;
  assign F_Y     = f_y_r;
  assign K_1     = k_out1_r;
  assign K_2     = k_out2_r;
  assign K_3     = k_out3_r;
  assign K_4     = k_out4_r;
  assign K_VALID = k_valid_r;

endmodule

// File: tb/tb_rk4_k_sequencer.sv
// tb_rk4_k_sequencer -- directed bench for rk4_k_sequencer with a small f()
// responder (f=y or a fixed value, configurable ack delay and stray acks).
module tb_rk4_k_sequencer;
  import rk4_pkg::*;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b1;
  logic         START = 1'b0;
  logic [W-1:0] T_IN = '0, Y_IN = '0, H = '0;
  logic         BUSY, F_REQ, K_VALID;
  logic [W-1:0] F_T, F_Y, K_1, K_2, K_3, K_4;
  logic         F_ACK = 1'b0;
  logic [W-1:0] F_VAL = '0;

  int vec_cnt = 0;
  int err_cnt = 0;

  // responder configuration
  int           ack_delay = 0;
  int           wait_cnt  = 0;
  logic         use_fixed = 1'b0;
  logic [W-1:0] fixed_val = '0;
  logic         stray_ack = 1'b0;

  // per-step observations
  logic [W-1:0] ft_seq [4];
  int           req_cnt;
  int           kv_lat;
  logic         stable_ok;
  logic         gap_ok;

  rk4_k_sequencer #(.N(32), .FRAC(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START),
    .T_IN(T_IN), .Y_IN(Y_IN), .H(H),
    .BUSY(BUSY), .F_REQ(F_REQ), .F_T(F_T), .F_Y(F_Y),
    .F_ACK(F_ACK), .F_VAL(F_VAL),
    .K_1(K_1), .K_2(K_2), .K_3(K_3), .K_4(K_4),
    .K_VALID(K_VALID)
  );

  always #5 CLK = ~CLK;

  // f() responder: acts 1 time unit after each edge, ahead of the main thread.
  always @(posedge CLK) begin
    #1;
    if (RST_N && F_REQ) begin
      if (wait_cnt >= ack_delay) begin
        F_ACK = 1'b1;
        F_VAL = use_fixed ? fixed_val : F_Y;
      end else begin
        F_ACK = stray_ack;
        F_VAL = 32'hDEAD_BEEF;
      end
      wait_cnt++;
    end else begin
      F_ACK    = RST_N ? stray_ack : 1'b0;
      F_VAL    = 32'hDEAD_BEEF;
      wait_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Pulse START and follow the step until K_VALID (bounded), recording the
  // F_T sequence, argument stability and the request gap length.
  task automatic run_step(input logic [W-1:0] t, input logic [W-1:0] y,
                          input logic [W-1:0] h, input logic noise);
    logic         prev_req;
    logic [W-1:0] hold_t, hold_y;
    int           gap;
    T_IN = t; Y_IN = y; H = h; START = 1'b1;
    stray_ack = noise;
    tick();
    START = 1'b0;
    req_cnt = 0; kv_lat = -1; stable_ok = 1'b1; gap_ok = 1'b1;
    prev_req = 1'b0; gap = 0; hold_t = '0; hold_y = '0;
    for (int c = 0; c < 100; c++) begin
      if (K_VALID) begin
        kv_lat = c;
        break;
      end
      if (F_REQ && !prev_req) begin
        if (req_cnt < 4) ft_seq[req_cnt] = F_T;
        if (req_cnt > 0 && gap != 1) gap_ok = 1'b0;
        req_cnt++;
        hold_t = F_T; hold_y = F_Y; gap = 0;
      end else if (F_REQ) begin
        if (F_T !== hold_t || F_Y !== hold_y) stable_ok = 1'b0;
      end else begin
        gap++;
      end
      prev_req = F_REQ;
      if (noise && c == 3) START = 1'b1;
      if (noise && c == 5) START = 1'b0;
      tick();
    end
    START = 1'b0;
    stray_ack = 1'b0;
    if (kv_lat < 0) check("kvalid_timeout", 32'd0, 32'd1);
  endtask

  // Expected results of the f=y step (t=0, y=1.0, h=1.0).
  task automatic check_fy(input string tag, input int lat);
    check({tag, "_k1"}, K_1, 32'h0001_0000);
    check({tag, "_k2"}, K_2, 32'h0001_8000);
    check({tag, "_k3"}, K_3, 32'h0001_C000);
    check({tag, "_k4"}, K_4, 32'h0002_C000);
    check({tag, "_lat"}, 32'(kv_lat), 32'(lat));
    check({tag, "_nreq"}, 32'(req_cnt), 32'd4);
    check({tag, "_ft0"}, ft_seq[0], 32'h0000_0000);
    check({tag, "_ft1"}, ft_seq[1], HALF);
    check({tag, "_ft2"}, ft_seq[2], HALF);
    check({tag, "_ft3"}, ft_seq[3], ONE);
    check({tag, "_stable"}, 32'(stable_ok), 32'd1);
    check({tag, "_gap"}, 32'(gap_ok), 32'd1);
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
    tick();
    check({tag, "_kv_pulse"}, 32'(K_VALID), 32'd0);
    check({tag, "_k4_hold"}, K_4, 32'h0002_C000);
  endtask

  initial begin
    int kv_seen;

    // power-on reset
    #1 RST_N = 1'b0;
    #1;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_freq", 32'(F_REQ), 32'd0);
    check("rst_kvalid", 32'(K_VALID), 32'd0);
    check("rst_k1", K_1, 32'd0);
    repeat (2) tick();
    RST_N = 1'b1;
    tick();

    // f = y, zero-wait ack
    run_step(32'd0, ONE, ONE, 1'b0);
    check_fy("fy", 8);

    // negative slope: h=0.5, f=-1.0
    use_fixed = 1'b1; fixed_val = 32'hFFFF_0000;
    run_step(32'd0, 32'd0, 32'h0000_8000, 1'b0);
    check("neg_k1", K_1, 32'hFFFF_8000);
    check("neg_k4", K_4, 32'hFFFF_8000);
    tick();

    // product overflow, positive and negative
    fixed_val = 32'h0002_0000;
    run_step(32'd0, 32'd0, 32'h7FFF_0000, 1'b0);
`ifdef RK4_SAT_EN
    check("ovf_pos_k1", K_1, 32'h7FFF_FFFF);
`else
    check("ovf_pos_k1", K_1, 32'hFFFE_0000);
`endif
    tick();
    fixed_val = 32'hFFFE_0000;
    run_step(32'd0, 32'd0, 32'h7FFF_0000, 1'b0);
`ifdef RK4_SAT_EN
    check("ovf_neg_k1", K_1, 32'h8000_0000);
`else
    check("ovf_neg_k1", K_1, 32'h0002_0000);
`endif
    tick();
    use_fixed = 1'b0;

    // three wait cycles per request: 8 + 4*3 cycles to K_VALID
    ack_delay = 3;
    run_step(32'd0, ONE, ONE, 1'b0);
    check_fy("wait", 20);
    ack_delay = 0;

    // reset while the EVAL3 request is outstanding
    T_IN = 32'd0; Y_IN = ONE; H = ONE; START = 1'b1;
    tick();
    START = 1'b0;
    repeat (4) tick();
    check("mid_freq", 32'(F_REQ), 32'd1);
    check("mid_ft", F_T, HALF);
    #1 RST_N = 1'b0;
    #1;
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    check("mid_rst_freq", 32'(F_REQ), 32'd0);
    check("mid_rst_ft", F_T, 32'd0);
    check("mid_rst_fy", F_Y, 32'd0);
    check("mid_rst_k1", K_1, 32'd0);
    check("mid_rst_k4", K_4, 32'd0);
    repeat (2) tick();
    RST_N = 1'b1;
    kv_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (K_VALID) kv_seen++;
    end
    check("mid_no_kvalid", 32'(kv_seen), 32'd0);
    check("mid_idle_busy", 32'(BUSY), 32'd0);
    run_step(32'd0, ONE, ONE, 1'b0);
    check_fy("post_rst", 8);

    // START while busy and acks while F_REQ is low must be ignored
    run_step(32'd0, ONE, ONE, 1'b1);
    check_fy("noise", 8);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/rk4_k_sequencer.md
RK4_K_SEQUENCER -- requirements
Module: rk4_k_sequencer

Interface
REQ-001 SHALL have parameter N, default 32, meaning data word width (signed fixed point).
REQ-002 SHALL have parameter FRAC, default 16, meaning fractional bits (Q16.16 at defaults).
REQ-003 SHALL provide ports, in this order:
- CLK  in  1  sole clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  begin one RK4 step.
- T_IN  in  N  current t.
- Y_IN  in  N  current y.
- H  in  N  step size.
- BUSY  out  1  step in progress.
- F_REQ  out  1  request evaluation of f(F_T, F_Y).
- F_T  out  N  f argument t.
- F_Y  out  N  f argument y.
- F_ACK  in  1  f result valid on F_VAL.
- F_VAL  in  N  f result.
- K_1, K_2, K_3, K_4  out  N each  slopes for the downstream Y calculation.
- K_VALID  out  1  one-cycle pulse when K_1..K_4 are updated.

Function
REQ-004 SHALL implement FSM states IDLE, EVAL1, EVAL2, EVAL3, EVAL4, DONE.
REQ-005 START sampled in IDLE SHALL latch T_IN, Y_IN, H and move to EVAL1; START outside IDLE SHALL be ignored.
REQ-006 SHALL drive these f arguments:
- EVAL1: F_T=t, F_Y=y.
- EVAL2: F_T=t+h/2, F_Y=y+k1/2.
- EVAL3: F_T=t+h/2, F_Y=y+k2/2.
- EVAL4: F_T=t+h, F_Y=y+k3.
- Halving SHALL be an arithmetic right shift by 1; additions SHALL be N-bit two's-complement wrap.
REQ-007 F_REQ SHALL be registered and held high with F_T/F_Y stable until F_ACK is sampled high.
REQ-008 F_REQ SHALL be low for exactly one cycle after each accepted F_ACK before the next request.
REQ-009 F_ACK SHALL be ignored while F_REQ is low.
REQ-010 On an accepted F_ACK in EVALn, kn SHALL be registered as h*F_VAL and the FSM SHALL advance (EVAL4 advances to DONE).
REQ-011 The h*F_VAL product SHALL be a full 2N-bit signed product, bits [N+FRAC-1:FRAC] taken (truncation toward negative infinity).
REQ-012 DONE SHALL last one cycle: K_1..K_4 update, K_VALID=1, next state IDLE.
REQ-013 K outputs SHALL hold their values until the next DONE.
REQ-014 BUSY SHALL be 1 in every state except IDLE.
REQ-015 With F_ACK returned in the first F_REQ cycle, K_VALID SHALL assert 8 cycles after the START sampling edge.

Reset
REQ-016 RST_N low SHALL asynchronously force IDLE and clear every output to 0 (BUSY, F_REQ, F_T, F_Y, K_1..K_4, K_VALID) and all latched operands.
REQ-017 Reset asserted mid-step SHALL abort the step with no K_VALID; START is honoured from the first clock edge after release.

Configuration
REQ-018 With RK4_SAT_EN defined, product overflow SHALL saturate to 0x7FFFFFFF (positive) or 0x80000000 (negative) at N=32.
REQ-019 Without RK4_SAT_EN, product overflow SHALL wrap (low bits kept).

Structure
REQ-020 Package rk4_pkg SHALL hold N/FRAC defaults, the FSM state enumeration, and the Q16.16 constants ONE=0x00010000 and HALF=0x00008000.
REQ-021 Sub-module fx_mul_q16 (signed fixed-point multiply, saturation under RK4_SAT_EN) SHALL be instantiated once and shared across the four evaluations.

Verification
REQ-022 The bench SHALL cover these scenarios (model f=y, zero-wait ack unless stated):
- f=y: T_IN=0, Y_IN=0x00010000, H=0x00010000 -> F_T sequence 0, 0x8000, 0x8000, 0x10000; K_1=0x00010000, K_2=0x00018000, K_3=0x0001C000, K_4=0x0002C000; K_VALID 8 cycles after START.
- Negative slope: H=0x00008000, F_VAL=0xFFFF0000 -> K_1=0xFFFF8000.
- Overflow: H=0x7FFF0000, F_VAL=0x00020000 -> K_1=0x7FFFFFFF with RK4_SAT_EN; 0xFFFE0000 without.
- Wait states: F_ACK delayed 3 cycles per request -> F_REQ and F_T/F_Y stable throughout; F_REQ one-cycle low gap after each ack; results identical to the f=y scenario.
- Reset mid-EVAL3 -> all outputs 0 immediately; no K_VALID; a fresh START afterwards completes normally.
- START pulsed while BUSY, and F_ACK pulsed while F_REQ low -> both ignored; outputs match the f=y scenario.
